// File: rtl/timer_a_pkg.sv
// Shared Timer_A encodings for clock source select and both divider stages,
// plus the prescale ratio decode.
package timer_a_pkg;

    localparam logic [1:0] TASSEL__TACLK = 2'd0;
    localparam logic [1:0] TASSEL__ACLK  = 2'd1;
    localparam logic [1:0] TASSEL__SMCLK = 2'd2;
    localparam logic [1:0] TASSEL__INCLK = 2'd3;

    localparam logic [1:0] ID__1 = 2'd0;
    localparam logic [1:0] ID__2 = 2'd1;
    localparam logic [1:0] ID__4 = 2'd2;
    localparam logic [1:0] ID__8 = 2'd3;

    localparam logic [2:0] IDEX__1 = 3'd0;
    localparam logic [2:0] IDEX__2 = 3'd1;
    localparam logic [2:0] IDEX__3 = 3'd2;
    localparam logic [2:0] IDEX__4 = 3'd3;
    localparam logic [2:0] IDEX__5 = 3'd4;
    localparam logic [2:0] IDEX__6 = 3'd5;
    localparam logic [2:0] IDEX__7 = 3'd6;
    localparam logic [2:0] IDEX__8 = 3'd7;

    localparam int DIV_N_W = 7;

    // Total ratio (2^ID)*(IDEX+1); largest case 8*8 = 64 still fits in 7 bits.
    function automatic logic [DIV_N_W-1:0] calcDivN(input logic [1:0] id, input logic [2:0] idex);
        logic [DIV_N_W-1:0] expRatio;
        expRatio = DIV_N_W'({1'b0, idex} + 4'd1);
        return expRatio << id;
    endfunction

endpackage

// File: rtl/timer_a_clk_mux.sv
// Timer_A 4:1 source clock select. Plain combinational mux; software only
// switches TASSEL with the timer stopped and clears afterwards.
module timer_a_clk_mux
    import timer_a_pkg::*;
(
    input  logic       TAxCLK,
    input  logic       ACLK,
    input  logic       SMCLK,
    input  logic       INCLK,
    input  logic [1:0] TASSEL,
    output logic       srcClk
);

    always_comb begin
        srcClk = TAxCLK;
        case (TASSEL)
            TASSEL__TACLK: srcClk = TAxCLK;
            TASSEL__ACLK:  srcClk = ACLK;
            TASSEL__SMCLK: srcClk = SMCLK;
            TASSEL__INCLK: srcClk = INCLK;
            default:       srcClk = TAxCLK;
        endcase
    end

endmodule

// File: rtl/timer_a_pre_div.sv
// Timer_A clock prescaler: selects a source and divides it by (2^ID)*(IDEX+1),
// producing TimerClock for the TAxR counter. TACLR restarts the prescale phase.
module timer_a_pre_div
    import timer_a_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic       TAxCLK,
    input  logic       ACLK,
    input  logic       SMCLK,
    input  logic       INCLK,
    input  logic       reset,
    input  logic       wTACLR,
    input  logic [1:0] TASSEL,
    input  logic [1:0] ID,
    input  logic [2:0] IDEX,
    output logic       TimerClock
);

    logic                srcClk;
    logic                clear;
    logic                divReg;
    logic [CNT_W-1:0]    divCount;
    logic [DIV_N_W-1:0]  divN;
    logic [DIV_N_W-1:0]  countExt;

    timer_a_clk_mux uClkMux (
        .TAxCLK (TAxCLK),
        .ACLK   (ACLK),
        .SMCLK  (SMCLK),
        .INCLK  (INCLK),
        .TASSEL (TASSEL),
        .srcClk (srcClk)
    );

    assign divN     = calcDivN(ID, IDEX);
    assign countExt = DIV_N_W'(divCount);

    // TACLR strobes can be shorter than a source period, so it joins reset as an async clear.
    assign clear = ~reset | wTACLR;

    // The >= wrap test keeps the count bounded when the ratio shrinks mid-count.
    always_ff @(posedge srcClk or posedge clear) begin
        if (clear) begin
            divCount <= '0;
            divReg   <= 1'b0;
        end else begin
            divReg   <= (countExt < (divN >> 1));
            divCount <= (countExt >= (divN - 7'd1)) ? '0 : divCount + 1'b1;
        end
    end

    assign TimerClock = (divN == 7'd1) ? (srcClk & ~clear) : divReg;

endmodule

// File: tb/tb_timer_a_pre_div.sv
// Randomized self-checking bench for timer_a_pre_div; expected waveforms come
// from the divide ratio and the number of source edges since the last clear.
`timescale 1ns/100ps
module tb_timer_a_pre_div;

    logic       TAxCLK = 1'b0;
    logic       ACLK   = 1'b0;
    logic       SMCLK  = 1'b0;
    logic       INCLK  = 1'b0;
    logic       reset;
    logic       wTACLR;
    logic [1:0] TASSEL;
    logic [1:0] ID;
    logic [2:0] IDEX;
    logic       TimerClock;

    int assertCount = 0;
    int failCount   = 0;
    int sinceClear  = 0;
    int curN        = 1;

    wire benchSrc = (TASSEL == 2'd0) ? TAxCLK :
                    (TASSEL == 2'd1) ? ACLK   :
                    (TASSEL == 2'd2) ? SMCLK  : INCLK;

    always #7    TAxCLK = ~TAxCLK;
    always #11.5 ACLK   = ~ACLK;
    always #5    SMCLK  = ~SMCLK;
    always #15.5 INCLK  = ~INCLK;

    timer_a_pre_div dut (
        .TAxCLK     (TAxCLK),
        .ACLK       (ACLK),
        .SMCLK      (SMCLK),
        .INCLK      (INCLK),
        .reset      (reset),
        .wTACLR     (wTACLR),
        .TASSEL     (TASSEL),
        .ID         (ID),
        .IDEX       (IDEX),
        .TimerClock (TimerClock)
    );

    task automatic checkOutput(input string tag, input int got, input int exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the k-th source posedge after clear starts phase (k-1) mod N, high in the first floor(N/2) phases.
    function automatic int expectOut(input int k, input int n);
        if (n == 1) return 1;
        return (((k - 1) % n) < (n / 2)) ? 1 : 0;
    endfunction

    task automatic applyStimulus(input logic [1:0] id, input logic [2:0] idex);
        ID   = id;
        IDEX = idex;
        curN = (1 << id) * (int'(idex) + 1);
    endtask

    task automatic pulseClear(input bit doCheck);
        @(negedge SMCLK);
        #1 wTACLR = 1'b1;
        #1;
        if (doCheck) begin
            checkOutput("clear TimerClock", int'(TimerClock), 0);
            checkOutput("clear divCount", int'(dut.divCount), 0);
        end
        wTACLR = 1'b0;
        sinceClear = 0;
    endtask

    task automatic stepCheck(input string tag, input int steps);
        for (int i = 0; i < steps; i++) begin
            @(posedge SMCLK);
            #1;
            sinceClear++;
            checkOutput(tag, int'(TimerClock), expectOut(sinceClear, curN));
        end
    endtask

    task automatic waitEdge(input string tag, input bit rising, input int limit, output realtime t);
        logic prev;
        bit   found;
        prev  = TimerClock;
        found = 1'b0;
        t     = $realtime;
        for (int i = 0; i < limit && !found; i++) begin
            #1;
            if (rising ? (!prev && TimerClock) : (prev && !TimerClock)) begin
                t     = $realtime;
                found = 1'b1;
            end
            prev = TimerClock;
        end
        if (!found) checkOutput({tag, " edge timeout"}, 0, 1);
    endtask

    task automatic measureCode(input string tag, input int n);
        realtime tFall1, tRise, tFall2;
        waitEdge(tag, 1'b0, 1500, tFall1);
        waitEdge(tag, 1'b1, 1500, tRise);
        waitEdge(tag, 1'b0, 1500, tFall2);
        checkOutput({tag, " period"}, int'(tFall2 - tFall1), n * 10);
        checkOutput({tag, " high"}, int'(tFall2 - tRise), (n == 1) ? 5 : (n / 2) * 10);
    endtask

    initial begin
        reset  = 1'b0;
        wTACLR = 1'b0;
        TASSEL = 2'd0;
        applyStimulus(2'd0, 3'd0);
        #20;
        checkOutput("reset TimerClock", int'(TimerClock), 0);
        checkOutput("reset divCount", int'(dut.divCount), 0);
        reset = 1'b1;

        // T1: undivided output follows each selected source.
        for (int sel = 0; sel < 4; sel++) begin
            TASSEL = 2'(sel);
            for (int p = 0; p < 3; p++) begin
                @(posedge benchSrc);
                #1 checkOutput($sformatf("T1 sel%0d high", sel), int'(TimerClock), 1);
                @(negedge benchSrc);
                #1 checkOutput($sformatf("T1 sel%0d low", sel), int'(TimerClock), 0);
            end
        end

        // T2: N=6 on SMCLK.
        TASSEL = 2'd2;
        applyStimulus(2'd1, 3'd2);
        pulseClear(1'b1);
        stepCheck("T2 first rise", 1);
        measureCode("T2", 6);

        // T3: every ratio code.
        for (int code = 0; code < 32; code++) begin
            applyStimulus(2'(code >> 3), 3'(code & 7));
            pulseClear(1'b0);
            measureCode($sformatf("T3 code%0d", code), curN);
        end

        // T4: N=64 with a mid-count TACLR.
        applyStimulus(2'd3, 3'd7);
        pulseClear(1'b1);
        stepCheck("T4 pre", 20);
        pulseClear(1'b1);
        stepCheck("T4 post", 130);

        // T5: reset mid-count at N=64, then at N=1.
        stepCheck("T5 pre", 30);
        @(negedge SMCLK);
        #1 reset = 1'b0;
        #1 checkOutput("T5 reset divCount", int'(dut.divCount), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge SMCLK);
            #1 checkOutput("T5 held", int'(TimerClock), 0);
        end
        @(negedge SMCLK);
        #1 reset = 1'b1;
        sinceClear = 0;
        stepCheck("T5 post", 130);
        applyStimulus(2'd0, 3'd0);
        @(negedge SMCLK);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge SMCLK);
            #1 checkOutput("T5 N1 held", int'(TimerClock), 0);
        end
        @(negedge SMCLK);
        #1 reset = 1'b1;
        sinceClear = 0;
        stepCheck("T5 N1 post", 4);

        // T6: ratio shrinks from 64 to 2 while divCount sits at 40.
        applyStimulus(2'd3, 3'd7);
        pulseClear(1'b0);
        stepCheck("T6 pre", 40);
        checkOutput("T6 divCount", int'(dut.divCount), 40);
        @(negedge SMCLK);
        applyStimulus(2'd0, 3'd1);
        @(posedge SMCLK);
        #1;
        checkOutput("T6 wrap TimerClock", int'(TimerClock), 0);
        checkOutput("T6 wrap divCount", int'(dut.divCount), 0);
        sinceClear = 0;
        stepCheck("T6 div2", 12);

        // Random ratios with a clear at a random point in the count.
        for (int trial = 0; trial < 10; trial++) begin
            applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            pulseClear(1'b1);
            stepCheck($sformatf("rand%0d run", trial), curN + int'($urandom_range(1, curN)));
            pulseClear(1'b1);
            stepCheck($sformatf("rand%0d restart", trial), 2 * curN + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
